// File: rtl/irq_priority_encoder_if.sv
// Request/presentation bus of the interrupt priority encoder.
// Request side is active-low; code side uses a valid/ack handshake.
interface irq_priority_encoder_if;
  logic [7:0] iReq;
  logic [1:0] iEna;
  logic       iAck;
  logic [2:0] oCode;
  logic       oValid;
  logic [7:0] oPendN;
  logic       oBusy;

  modport master (
    output iReq,
    output iEna,
    output iAck,
    input  oCode,
    input  oValid,
    input  oPendN,
    input  oBusy
  );

  modport slave (
    input  iReq,
    input  iEna,
    input  iAck,
    output oCode,
    output oValid,
    output oPendN,
    output oBusy
  );
endinterface

// File: rtl/irq_priority_encoder.sv
// Registered 8-to-3 priority encoder with request latching.
// Presents one pending line at a time and holds it until acknowledged.
module irq_priority_encoder #(
  parameter bit         PRIO_HIGH = 1'b1,
  parameter logic [1:0] EN_CODE   = 2'b10
) (
  input logic                   iClk,
  input logic                   iRst,
  irq_priority_encoder_if.slave bus
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] pending;
  logic [7:0] pending_nx;
  logic [7:0] clear;
  logic [2:0] code;
  logic [2:0] code_nx;
  logic [2:0] winner;
  logic       en;

  assign en = (bus.iEna == EN_CODE);

  always_comb begin
    winner = '0;
    if (PRIO_HIGH) begin
      for (int i = 0; i < 8; i++) begin
        if (pending[i]) winner = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pending[i]) winner = 3'(i);
      end
    end
  end

  always_comb begin
    state_nx = state;
    code_nx  = code;
    clear    = '0;
    unique case (state)
      IDLE: begin
        if (en && (pending != '0)) begin
          code_nx  = winner;
          state_nx = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.iAck) begin
          clear    = 8'b1 << code;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A line still held low on the ack edge re-sets its bit.
    pending_nx = pending & ~clear;
    if (en) pending_nx = pending_nx | ~bus.iReq;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= IDLE;
      pending <= '0;
      code    <= '0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      code    <= code_nx;
    end
  end

  assign bus.oCode  = code;
  assign bus.oValid = (state == PRESENT);
  assign bus.oPendN = ~pending;
  assign bus.oBusy  = (pending != '0) || (state == PRESENT);

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Bench for irq_priority_encoder: two instances (high and low priority
// order) share stimulus; expected codes are queued and popped on valid.
module tb_irq_priority_encoder;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  logic [2:0] q_hi[$];
  logic [2:0] q_lo[$];
  logic [2:0] exp_c;

  irq_priority_encoder_if bus ();
  irq_priority_encoder_if lo ();

  assign lo.iReq = bus.iReq;
  assign lo.iEna = bus.iEna;
  assign lo.iAck = bus.iAck;

  irq_priority_encoder #(
    .PRIO_HIGH(1'b1),
    .EN_CODE  (2'b10)
  ) dut_hi (
    .iClk(clk),
    .iRst(rst),
    .bus (bus.slave)
  );

  irq_priority_encoder #(
    .PRIO_HIGH(1'b0),
    .EN_CODE  (2'b10)
  ) dut_lo (
    .iClk(clk),
    .iRst(rst),
    .bus (lo.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    bus.iReq = 8'h00;
    bus.iEna = 2'b10;
    bus.iAck = 1'b0;
    step();
    step();
    n_chk++;
    if (bus.oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b exp 0", bus.oValid);
    end
    n_chk++;
    if (bus.oCode !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_code got %0d exp 0", bus.oCode);
    end
    n_chk++;
    if (bus.oPendN !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_pendn got %h exp ff", bus.oPendN);
    end
    n_chk++;
    if (bus.oBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b exp 0", bus.oBusy);
    end
    bus.iReq = 8'hFF;
    rst      = 1'b0;
    step();
  endtask

  task automatic test_single();
    bus.iReq = 8'b1111_1011;
    q_hi.push_back(3'd2);
    step();
    n_chk++;
    if (bus.oPendN !== 8'b1111_1011) begin
      n_fail++;
      $display("FAIL single_pendn got %h exp fb", bus.oPendN);
    end
    n_chk++;
    if (bus.oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early_valid got %b exp 0", bus.oValid);
    end
    bus.iReq = 8'hFF;
    step();
    n_chk++;
    if (bus.oValid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_valid got %b exp 1", bus.oValid);
    end
    exp_c = q_hi.pop_front();
    n_chk++;
    if (bus.oCode !== exp_c) begin
      n_fail++;
      $display("FAIL single_code got %0d exp %0d", bus.oCode, exp_c);
    end
    bus.iAck = 1'b1;
    step();
    bus.iAck = 1'b0;
    n_chk++;
    if (bus.oValid !== 1'b0 || bus.oPendN !== 8'hFF || bus.oBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ack got v=%b p=%h b=%b exp v=0 p=ff b=0",
               bus.oValid, bus.oPendN, bus.oBusy);
    end
  endtask

  task automatic test_priority();
    rst = 1'b1;
    step();
    rst = 1'b0;
    q_hi.push_back(3'd5);
    q_hi.push_back(3'd7);
    q_hi.push_back(3'd1);
    q_lo.push_back(3'd1);
    q_lo.push_back(3'd5);
    q_lo.push_back(3'd7);
    bus.iReq = 8'b1101_1101;
    step();
    bus.iReq = 8'hFF;
    step();
    bus.iReq = 8'b0111_1111;
    step();
    bus.iReq = 8'hFF;
    step();
    step();
    n_chk++;
    if (bus.oValid !== 1'b1 || bus.oCode !== 3'd5) begin
      n_fail++;
      $display("FAIL prio_hold got v=%b c=%0d exp v=1 c=5",
               bus.oValid, bus.oCode);
    end
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 4 && bus.oValid !== 1'b1; t++) step();
      n_chk++;
      if (bus.oValid !== 1'b1) begin
        n_fail++;
        $display("FAIL prio_timeout k=%0d got v=%b exp 1", k, bus.oValid);
      end
      exp_c = q_hi.pop_front();
      n_chk++;
      if (bus.oCode !== exp_c) begin
        n_fail++;
        $display("FAIL prio_hi_code k=%0d got %0d exp %0d", k, bus.oCode, exp_c);
      end
      exp_c = q_lo.pop_front();
      n_chk++;
      if (lo.oValid !== 1'b1 || lo.oCode !== exp_c) begin
        n_fail++;
        $display("FAIL prio_lo_code k=%0d got v=%b c=%0d exp v=1 c=%0d",
                 k, lo.oValid, lo.oCode, exp_c);
      end
      bus.iAck = 1'b1;
      step();
      bus.iAck = 1'b0;
    end
    n_chk++;
    if (bus.oBusy !== 1'b0 || lo.oBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_drain got hi=%b lo=%b exp 0", bus.oBusy, lo.oBusy);
    end
  endtask

  task automatic test_disabled();
    bus.iEna = 2'b01;
    bus.iReq = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++;
      if (bus.oValid !== 1'b0) begin
        n_fail++;
        $display("FAIL dis_valid cyc=%0d got %b exp 0", i, bus.oValid);
      end
    end
    n_chk++;
    if (bus.oPendN !== 8'hFF) begin
      n_fail++;
      $display("FAIL dis_pendn got %h exp ff", bus.oPendN);
    end
    bus.iReq = 8'hFF;
    bus.iEna = 2'b10;
  endtask

  task automatic test_dis_mid();
    bus.iReq = 8'b1111_0111;
    q_hi.push_back(3'd3);
    q_hi.push_back(3'd0);
    step();
    bus.iReq = 8'hFF;
    step();
    exp_c = q_hi.pop_front();
    n_chk++;
    if (bus.oValid !== 1'b1 || bus.oCode !== exp_c) begin
      n_fail++;
      $display("FAIL dmid_code got v=%b c=%0d exp v=1 c=%0d",
               bus.oValid, bus.oCode, exp_c);
    end
    bus.iReq = 8'b1111_1110;
    step();
    bus.iReq = 8'hFF;
    bus.iEna = 2'b00;
    bus.iAck = 1'b1;
    step();
    bus.iAck = 1'b0;
    n_chk++;
    if (bus.oValid !== 1'b0 || bus.oPendN !== 8'hFE) begin
      n_fail++;
      $display("FAIL dmid_ack got v=%b p=%h exp v=0 p=fe",
               bus.oValid, bus.oPendN);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (bus.oValid !== 1'b0) begin
        n_fail++;
        $display("FAIL dmid_hold cyc=%0d got %b exp 0", i, bus.oValid);
      end
    end
    bus.iEna = 2'b10;
    step();
    exp_c = q_hi.pop_front();
    n_chk++;
    if (bus.oValid !== 1'b1 || bus.oCode !== exp_c) begin
      n_fail++;
      $display("FAIL dmid_resume got v=%b c=%0d exp v=1 c=%0d",
               bus.oValid, bus.oCode, exp_c);
    end
    bus.iAck = 1'b1;
    step();
    bus.iAck = 1'b0;
  endtask

  task automatic test_collision();
    bus.iReq = 8'b1110_1111;
    q_hi.push_back(3'd4);
    q_hi.push_back(3'd4);
    step();
    step();
    exp_c = q_hi.pop_front();
    n_chk++;
    if (bus.oValid !== 1'b1 || bus.oCode !== exp_c) begin
      n_fail++;
      $display("FAIL coll_first got v=%b c=%0d exp v=1 c=%0d",
               bus.oValid, bus.oCode, exp_c);
    end
    bus.iAck = 1'b1;
    step();
    bus.iAck = 1'b0;
    n_chk++;
    if (bus.oValid !== 1'b0 || bus.oPendN !== 8'hEF) begin
      n_fail++;
      $display("FAIL coll_keep got v=%b p=%h exp v=0 p=ef",
               bus.oValid, bus.oPendN);
    end
    step();
    exp_c = q_hi.pop_front();
    n_chk++;
    if (bus.oValid !== 1'b1 || bus.oCode !== exp_c) begin
      n_fail++;
      $display("FAIL coll_again got v=%b c=%0d exp v=1 c=%0d",
               bus.oValid, bus.oCode, exp_c);
    end
    rst = 1'b1;
    step();
    n_chk++;
    if (bus.oValid !== 1'b0 || bus.oCode !== 3'd0 ||
        bus.oPendN !== 8'hFF || bus.oBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got v=%b c=%0d p=%h b=%b exp v=0 c=0 p=ff b=0",
               bus.oValid, bus.oCode, bus.oPendN, bus.oBusy);
    end
    rst      = 1'b0;
    bus.iReq = 8'hFF;
    step();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_priority();
    test_disabled();
    test_dis_mid();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_priority_encoder.md
Name: irq_priority_encoder

Overview:
- Registered 8-to-3 priority encoder with request latching and a valid/ack handshake.
- It is the encode-side counterpart of the team's active-low 3-to-8 line decoder and uses the same conventions: active-low request lines, enable active when iEna == 2'b10.
- Latches asserted request lines, presents the highest-priority pending index as a 3-bit code, and holds it until acknowledged.
- Feeding oCode into the 3-to-8 decoder regenerates the served line as an active-low one-hot.

Parameters:
- PRIO_HIGH, 1: 1 = line 7 has highest priority; 0 = line 0 has highest priority.
- EN_CODE, 2'b10: iEna value that enables capture and presentation.

Ports:
- iClk  input  1  clock; all state updates on rising edge.
- iRst  input  1  synchronous reset, active-high.
- iReq  input  8  request lines, active-low; bit k low = line k requesting.
- iEna  input  2  enable; block enabled only when iEna == EN_CODE.
- iAck  input  1  consumer acknowledge, sampled only while oValid = 1.
- oCode  output  3  index of the presented line; valid while oValid = 1.
- oValid  output  1  code presented.
- oPendN  output  8  active-low view of the pending register (bit low = pending).
- oBusy  output  1  high when any line is pending or oValid = 1.

Behaviour:
- Reset (iRst = 1 at a clock edge):
  - pending = 8'h00, oCode = 3'd0, oValid = 0, state = IDLE.
  - oPendN = 8'hFF, oBusy = 0.
  - Reset dominates all other inputs, including mid-presentation; an unacknowledged code is dropped.
- Capture, every edge while enabled:
  - pending_next = (pending & ~clear_mask) | ~iReq.
  - Requests are level-sampled, so a line held low re-sets its bit every cycle.
- Capture while disabled:
  - No capture; pending is held.
  - A presentation already in progress still completes normally, and its ack still clears its bit.
- State machine, two states: IDLE and PRESENT.
- IDLE:
  - If enabled and registered pending != 0: select winner w = highest set index (PRIO_HIGH = 1) or lowest set index (PRIO_HIGH = 0).
  - Load oCode = w, set oValid = 1, go to PRESENT.
  - Otherwise stay in IDLE with oValid = 0 and oCode holding its last value.
- PRESENT:
  - oCode and oValid are held stable. Newly arriving higher-priority requests do not change oCode; they only set pending bits.
  - On an edge with iAck = 1: clear_mask = one-hot(oCode), oValid = 0, go to IDLE.
  - The next winner is evaluated in IDLE on the following edge, so a code can be presented at most once every 2 cycles.
- Clear/set collision: if the served line is still low on the ack edge while enabled, set wins and the bit stays pending. That line is presented again later.
- iAck while IDLE (oValid = 0) is ignored.
- Latency: request low in the cycle before edge N sets pending at edge N; oValid rises at edge N+1. Minimum request-to-valid latency is 2 edges.
- Outputs:
  - oPendN = ~pending (registered).
  - oBusy = (pending != 0) | oValid (combinational from registers).
- Only enable value EN_CODE enables the block; all other iEna values disable it.

Test Plan:
- Reset: hold iRst = 1 for 2 cycles with iReq = 8'h00 and iEna = 2'b10 -> oValid = 0, oCode = 0, oPendN = 8'hFF, oBusy = 0.
- Single request: iReq = 8'b1111_1011 for 1 cycle, enabled -> oPendN = 8'b1111_1011 after 1 edge; oValid = 1 with oCode = 3'd2 after 2 edges; ack with iReq = 8'hFF -> oValid = 0, oPendN = 8'hFF, oBusy = 0.
- Priority and hold: pulse lines 1 and 5 together, then pulse line 7 while code 5 is presented:
  - Code 5 is held until ack.
  - With acks, codes then appear in order 7, 1 (PRIO_HIGH = 1).
  - With PRIO_HIGH = 0 and the same stimulus: order 1, 5, 7.
- Disabled: iEna = 2'b01 with iReq = 8'h00 for 5 cycles -> pending unchanged, oValid stays 0.
- Disabled mid-presentation: switch iEna to 2'b00 while code 3 is presented, then ack -> code 3 clears and no new code is presented until iEna = 2'b10.
- Collision and reset: hold line 4 low continuously and ack code 4 -> bit 4 stays pending and code 4 is re-presented 2 edges later. Assert iRst while oValid = 1 -> next edge all outputs return to their reset values.
